// File: rtl/uart_frame_loader_if.sv
// Byte-stream in / BRAM write port and status out for uart_frame_loader.
// data_valid is a one-cycle strobe that qualifies data_in; there is no ready, so the loader takes every strobe except one landing in its single DONE cycle, which is dropped.
interface uart_frame_loader_if #(
    parameter int ADDR_W = 19
);
    logic              data_valid;
    logic [7:0]        data_in;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              loading;
    logic              frame_done;
    logic [7:0]        frame_count;
    logic              timeout_err;

    modport master (
        output data_valid, data_in,
        input  wr_data, wr_addr, wr_en, loading, frame_done, frame_count, timeout_err
    );

    modport slave (
        input  data_valid, data_in,
        output wr_data, wr_addr, wr_en, loading, frame_done, frame_count, timeout_err
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Turns a UART byte stream (AA 55 header + FRAME_BYTES pixels) into sequential BRAM writes,
// with an inter-byte timeout that drops a stalled frame and hunts for the next header.
module uart_frame_loader #(
    parameter int         ADDR_W         = 19,
    parameter int         FRAME_BYTES    = 307200,
    parameter logic [7:0] SYNC0          = 8'hAA,
    parameter logic [7:0] SYNC1          = 8'h55,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_frame_loader_if.slave bus,
    output logic [1:0]        state_dbg
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_S0 = 2'd0,
        WAIT_S1 = 2'd1,
        LOAD    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] byte_cnt, byte_cnt_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic [7:0]        wr_data_q, wr_data_n;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
    logic              wr_en_q, wr_en_n;
    logic              frame_done_q, frame_done_n;
    logic [7:0]        frame_count_q, frame_count_n;
    logic              timeout_err_q, timeout_err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_S0;
            byte_cnt      <= '0;
            to_cnt        <= '0;
            wr_data_q     <= '0;
            wr_addr_q     <= '0;
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state         <= state_n;
            byte_cnt      <= byte_cnt_n;
            to_cnt        <= to_cnt_n;
            wr_data_q     <= wr_data_n;
            wr_addr_q     <= wr_addr_n;
            wr_en_q       <= wr_en_n;
            frame_done_q  <= frame_done_n;
            frame_count_q <= frame_count_n;
            timeout_err_q <= timeout_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        byte_cnt_n    = byte_cnt;
        to_cnt_n      = to_cnt;
        wr_data_n     = wr_data_q;
        wr_addr_n     = wr_addr_q;
        wr_en_n       = 1'b0;
        frame_done_n  = 1'b0;
        frame_count_n = frame_count_q;
        timeout_err_n = timeout_err_q;

        case (state)
            WAIT_S0: begin
                if (bus.data_valid && bus.data_in == SYNC0) begin
                    state_n = WAIT_S1;
                end
            end

            WAIT_S1: begin
                if (bus.data_valid) begin
                    if (bus.data_in == SYNC1) begin
                        state_n       = LOAD;
                        byte_cnt_n    = '0;
                        to_cnt_n      = '0;
                        timeout_err_n = 1'b0;
                    end else if (bus.data_in != SYNC0) begin
                        // A repeated SYNC0 keeps us here so AA AA 55 still locks.
                        state_n = WAIT_S0;
                    end
                end
            end

            LOAD: begin
                if (bus.data_valid) begin
                    // A byte arriving on the limit cycle still wins over the timeout.
                    wr_en_n   = 1'b1;
                    wr_data_n = bus.data_in;
                    wr_addr_n = byte_cnt;
                    to_cnt_n  = '0;
                    if (byte_cnt == ADDR_W'(FRAME_BYTES - 1)) begin
                        byte_cnt_n = '0;
                        state_n    = DONE;
                    end else begin
                        byte_cnt_n = byte_cnt + ADDR_W'(1);
                    end
                end else begin
                    if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                        to_cnt_n = to_cnt + TO_W'(1);
                    end
                    if (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_n       = WAIT_S0;
                        timeout_err_n = 1'b1;
                    end
                end
            end

            DONE: begin
                frame_done_n  = 1'b1;
                frame_count_n = frame_count_q + 8'd1;
                state_n       = WAIT_S0;
            end

            default: state_n = WAIT_S0;
        endcase
    end

    assign bus.wr_data     = wr_data_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.loading     = (state == LOAD);
    assign state_dbg       = state;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: vector table, hand-written corner sequences and random byte streams
// checked against a byte-level frame model and a write scoreboard.
module tb_uart_frame_loader;
    localparam int         ADDR_W = 19;
    localparam int         FB     = 4;
    localparam int         TO     = 1000;
    localparam logic [7:0] S0     = 8'hAA;
    localparam logic [7:0] S1     = 8'h55;
    localparam int         W      = ADDR_W + 8;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_loader_if #(.ADDR_W(ADDR_W)) bus();
    logic [1:0] state_dbg;

    uart_frame_loader #(
        .ADDR_W(ADDR_W), .FRAME_BYTES(FB), .SYNC0(S0), .SYNC1(S1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];
    int wr_seen   = 0;
    int done_seen = 0;

    // frame model: 0 hunting SYNC0, 1 seen SYNC0, 2 loading pixels
    int m_phase = 0;
    int m_idx   = 0;
    int m_idle  = 0;
    bit m_err   = 1'b0;
    int m_count = 0;
    int m_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus.wr_en === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected_write: got addr %0h data %0h expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_write", {5'd0, bus.wr_addr, bus.wr_data}, {5'd0, e});
            end
        end
        if (bus.frame_done === 1'b1) done_seen++;
    end

    task automatic m_timeout();
        if (m_phase == 2 && m_idle >= TO) begin
            m_phase = 0;
            m_err   = 1'b1;
        end
    endtask

    task automatic m_byte(input logic [7:0] b, output bit wrote, output int addr);
        wrote = 1'b0;
        addr  = 0;
        case (m_phase)
            0: if (b == S0) m_phase = 1;
            1: begin
                if (b == S1) begin
                    m_phase = 2;
                    m_idx   = 0;
                    m_err   = 1'b0;
                end else if (b != S0) begin
                    m_phase = 0;
                end
            end
            default: begin
                wrote = 1'b1;
                addr  = m_idx;
                exp_q.push_back({ADDR_W'(m_idx), b});
                m_idx++;
                if (m_idx == FB) begin
                    m_phase = 0;
                    m_count = (m_count + 1) % 256;
                    m_done++;
                end
            end
        endcase
        m_idle = 0;
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        m_idle += n;
        m_timeout();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit wrote;
        int addr;
        repeat (gap) @(posedge clk);
        m_idle += gap;
        m_timeout();
        #1;
        bus.data_valid = 1'b1;
        bus.data_in    = b;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'($urandom);
        m_byte(b, wrote, addr);
        if (wrote) begin
            check("wr_en_latency", {31'd0, bus.wr_en}, 32'd1);
            check("wr_addr", {13'd0, bus.wr_addr}, addr);
            check("wr_data", {24'd0, bus.wr_data}, {24'd0, b});
        end else begin
            check("wr_en_quiet", {31'd0, bus.wr_en}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_phase = 0; m_idx = 0; m_idle = 0; m_err = 1'b0; m_count = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        idle(3);
        check({tag, "_loading"}, {31'd0, bus.loading}, {31'd0, m_phase == 2});
        check({tag, "_timeout_err"}, {31'd0, bus.timeout_err}, {31'd0, m_err});
        check({tag, "_frame_count"}, {24'd0, bus.frame_count}, m_count);
        check({tag, "_frame_done_pulses"}, done_seen, m_done);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
        check({tag, "_wr_data"}, {24'd0, bus.wr_data}, 32'd0);
        check({tag, "_wr_addr"}, {13'd0, bus.wr_addr}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
        check({tag, "_frame_count"}, {24'd0, bus.frame_count}, 32'd0);
        check({tag, "_timeout_err"}, {31'd0, bus.timeout_err}, 32'd0);
        check({tag, "_loading"}, {31'd0, bus.loading}, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] seq[10];
        int         len;
        int         tail;
        int         exp_writes;
        bit         exp_load;
        bit         exp_err;
        int         exp_fc;
    } vec_t;

    vec_t tbl[7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : main
        int w0;
        int d0;
        logic [7:0] b;
        int gap;

        tbl[0] = '{'{8'hAA, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}, 6, 10, 4, 1'b0, 1'b0, 1};
        tbl[1] = '{'{8'h00, 8'hAA, 8'h12, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04}, 10, 10, 4, 1'b0, 1'b0, 1};
        tbl[2] = '{'{8'hAA, 8'h55, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1000, 2, 1'b0, 1'b1, 0};
        tbl[3] = '{'{8'hAA, 8'h55, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 10, 2, 1'b1, 1'b0, 0};
        tbl[4] = '{'{8'hAA, 8'h55, 8'hAA, 8'h55, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 6, 10, 4, 1'b0, 1'b0, 1};
        tbl[5] = '{'{8'h55, 8'hAA, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 10, 0, 1'b0, 1'b0, 0};
        tbl[6] = '{'{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'h55, 8'h09, 8'h00}, 9, 10, 5, 1'b1, 1'b0, 1};

        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset();
        check_all_zero("after_release");

        // vector table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            w0 = wr_seen;
            for (int j = 0; j < tbl[i].len; j++) send_byte(tbl[i].seq[j], 50);
            idle(tbl[i].tail);
            check_outputs($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_writes", i), wr_seen - w0, tbl[i].exp_writes);
            check($sformatf("tbl%0d_loading_c", i), {31'd0, bus.loading}, {31'd0, tbl[i].exp_load});
            check($sformatf("tbl%0d_err_c", i), {31'd0, bus.timeout_err}, {31'd0, tbl[i].exp_err});
            check($sformatf("tbl%0d_fc_c", i), {24'd0, bus.frame_count}, tbl[i].exp_fc);
        end

        // timeout then recovery on the next header
        do_reset();
        send_byte(8'hAA, 50); send_byte(8'h55, 50); send_byte(8'hA1, 50); send_byte(8'hA2, 50);
        idle(TO);
        check("to_state_wait_s0", {30'd0, state_dbg}, 32'd0);
        check("to_err_set", {31'd0, bus.timeout_err}, 32'd1);
        check("to_no_done", {24'd0, bus.frame_count}, 32'd0);
        send_byte(8'hAA, 50); send_byte(8'h55, 50);
        check("to_err_cleared", {31'd0, bus.timeout_err}, 32'd0);
        check("to_reload", {31'd0, bus.loading}, 32'd1);
        send_byte(8'hB1, 50); send_byte(8'hB2, 50); send_byte(8'hB3, 50); send_byte(8'hB4, 50);
        check_outputs("to_recover");
        check("to_recover_fc", {24'd0, bus.frame_count}, 32'd1);

        // timeout boundary: TO-1 idle cycles survive, TO idle cycles abort
        do_reset();
        send_byte(8'hAA, 20); send_byte(8'h55, 20); send_byte(8'hA1, 20);
        send_byte(8'hA2, TO - 1);
        check("edge_survive_err", {31'd0, bus.timeout_err}, 32'd0);
        check("edge_survive_load", {31'd0, bus.loading}, 32'd1);
        send_byte(8'h33, TO);
        check("edge_abort_err", {31'd0, bus.timeout_err}, 32'd1);
        check("edge_abort_load", {31'd0, bus.loading}, 32'd0);
        check_outputs("edge");

        // 256 back-to-back frames wrap frame_count
        do_reset();
        d0 = done_seen;
        for (int f = 0; f < 256; f++) begin
            send_byte(S0, 3); send_byte(S1, 3);
            for (int k = 0; k < FB; k++) send_byte(8'($urandom), 3);
        end
        check_outputs("b2b");
        check("b2b_fc_wrap", {24'd0, bus.frame_count}, 32'd0);
        check("b2b_done_pulses", done_seen - d0, 256);

        // reset in the middle of a frame
        do_reset();
        send_byte(8'hAA, 5); send_byte(8'h55, 5);
        send_byte(8'h01, 5); send_byte(8'h02, 5); send_byte(8'h03, 5); send_byte(8'h04, 5);
        idle(5);
        send_byte(8'hAA, 50); send_byte(8'h55, 50); send_byte(8'h11, 50); send_byte(8'h22, 50);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        m_phase = 0; m_idx = 0; m_idle = 0; m_err = 1'b0; m_count = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_seen;
        send_byte(8'h11, 50); send_byte(8'h22, 50); send_byte(8'h33, 50); send_byte(8'h44, 50);
        check_outputs("midrst_after");
        check("midrst_no_writes", wr_seen - w0, 0);

        // random byte streams with occasional long gaps around the timeout
        do_reset();
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: b = S0;
                3, 4:    b = S1;
                default: b = 8'($urandom);
            endcase
            gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 5, TO + 5) : $urandom_range(2, 60);
            send_byte(b, gap);
            if (n % 50 == 49) check_outputs($sformatf("rnd%0d", n));
        end
        check_outputs("rnd_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Sits between uart_rx and the ram_2port write port; turns the UART byte stream from the FT232 into sequential BRAM writes.
- Each frame starts with a two-byte sync header, followed by exactly FRAME_BYTES pixel bytes.
- Header bytes are never written.
- An inter-byte timeout aborts a stalled frame so the block resynchronises on the next header.

Parameters:
- ADDR_W, 19, BRAM write address width (640x480 = 307200 pixels).
- FRAME_BYTES, 307200, pixel bytes per frame.
- SYNC0, 8'hAA, first header byte.
- SYNC1, 8'h55, second header byte.
- TIMEOUT_CYCLES, 500000, idle clk cycles allowed between bytes in LOAD (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- data_valid  in  1  one-cycle strobe from uart_rx.
- data_in  in  8  byte from uart_rx; valid when data_valid=1.
- wr_data  out  8  to BRAM data.
- wr_addr  out  ADDR_W  to BRAM wraddress.
- wr_en  out  1  to BRAM wren; one-cycle pulse per pixel byte.
- loading  out  1  high while in LOAD.
- frame_done  out  1  one-cycle pulse after the last pixel write.
- frame_count  out  8  completed frames; wraps 255 -> 0.
- timeout_err  out  1  sticky; set on abort, cleared on entering LOAD.

Behaviour:
- Reset (async assert, sync release): state = WAIT_S0; wr_data, wr_addr, wr_en, frame_done, frame_count, timeout_err, the byte counter and the timeout counter all = 0. loading = 0.
- All outputs are registered except loading, which decodes the state register.
- State WAIT_S0, on data_valid:
  - data_in == SYNC0 -> WAIT_S1.
  - otherwise stay; byte discarded.
- State WAIT_S1, on data_valid:
  - data_in == SYNC1 -> LOAD; byte counter = 0; timeout counter = 0; timeout_err = 0.
  - data_in == SYNC0 -> stay in WAIT_S1 (so AA AA 55 is accepted).
  - anything else -> WAIT_S0.
- State LOAD, on data_valid at cycle t:
  - At t+1: wr_en = 1, wr_data = data_in, wr_addr = byte counter (zero-extended to ADDR_W).
  - Byte counter increments; timeout counter clears.
  - If byte counter was FRAME_BYTES-1 -> DONE.
  - Write latency is exactly 1 cycle.
- State LOAD, without data_valid:
  - Timeout counter increments.
  - When it reaches TIMEOUT_CYCLES -> WAIT_S0, timeout_err = 1, no write.
  - If data_valid arrives in the same cycle the limit is reached, the byte wins: it is written and the counter resets.
- State DONE (1 cycle): frame_done = 1 on the next cycle; frame_count += 1 (mod 256); -> WAIT_S0.
  - A data_valid in DONE is dropped. Cannot occur at 115200 baud (one byte ≈ 4340 cycles).
- wr_addr and wr_data hold their last value when wr_en = 0; they are not cleared between frames.
- wr_en is never high outside LOAD-originated writes; header bytes never produce wr_en.
- Partial frame after a timeout: BRAM keeps the partially written data. The next frame rewrites from address 0.
- Reset mid-LOAD: immediate return to reset values. No further writes; BRAM contents untouched.
- Byte counter width = ADDR_W; it never exceeds FRAME_BYTES-1.
- Timeout counter width = clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.

Test Plan:
- Use FRAME_BYTES=4, TIMEOUT_CYCLES=1000; drive data_valid pulses spaced 50 cycles apart.
- Basic frame: AA 55 11 22 33 44.
  - Expect 4 wr_en pulses at addr 0..3 carrying 11, 22, 33, 44, each 1 cycle after its data_valid.
  - Expect frame_done one pulse, frame_count = 1, loading low after.
- Resync: 00 AA 12 AA AA 55 01 02 03 04.
  - Expect no writes until the final header.
  - Expect writes of 01..04 at addr 0..3; frame_count = 1.
- Timeout: AA 55 A1 A2, then 1000 idle cycles.
  - Expect state WAIT_S0, timeout_err = 1, no frame_done.
  - Then AA 55 B1 B2 B3 B4: timeout_err clears at LOAD entry; writes at addr 0..3; frame_count = 1.
- Back-to-back frames: 256 complete frames.
  - Expect frame_count wraps to 0 and frame_done is pulsed 256 times.
- Reset mid-frame: assert rst_n = 0 after the 2nd pixel byte.
  - Expect all outputs 0 immediately (async) and no wr_en thereafter.
  - After release, 11 22 33 44 without a header produces no writes.
- Integration with uart_rx + ram_2port (default params scaled to FRAME_BYTES=4) at 115200 baud: AA 55 AB CD EF 01.
  - Expect read-back of BRAM[0..3] = AB, CD, EF, 01.
